// File: rtl/r4_butterfly_stream.sv
// r4_butterfly_stream: pipelined radix-4 DFT butterfly with streaming output.
// One block of four complex samples is accepted over a valid/ready handshake,
// all four outputs are computed and buffered on accept, then X0..X3 stream
// out one per cycle with full backpressure.
//
// Build option: define R4B_ROUND_EN to make the /4 scaling round half toward
// +inf instead of flooring.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | buffer empty, waiting for an input block (in_ready=1)
// EMIT  | presenting buffer[out_idx]; a new block may be accepted on
//       | the same cycle the final output (idx 3) is handed off

module r4_butterfly_stream #(
    parameter  int DW = 8,
    localparam int OW = DW + 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xr0,
    input  logic signed [DW-1:0] xr1,
    input  logic signed [DW-1:0] xr2,
    input  logic signed [DW-1:0] xr3,
    input  logic signed [DW-1:0] xi0,
    input  logic signed [DW-1:0] xi1,
    input  logic signed [DW-1:0] xi2,
    input  logic signed [DW-1:0] xi3,
    input  logic                 inv,
    input  logic                 scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] Xro,
    output logic signed [OW-1:0] Xio,
    output logic [1:0]           out_idx,
    output logic                 out_last
);

    localparam int IW = DW + 3;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                rdy_en_q;
    logic [1:0]          idx_q, idx_d, nidx;
    logic signed [OW-1:0] xro_q, xro_d, xio_q, xio_d;
    logic signed [OW-1:0] buf_r_q [4];
    logic signed [OW-1:0] buf_r_d [4];
    logic signed [OW-1:0] buf_i_q [4];
    logic signed [OW-1:0] buf_i_d [4];
    logic signed [OW-1:0] new_r [4];
    logic signed [OW-1:0] new_i [4];

    logic signed [IW-1:0] ar, br, cr, dr, ai, bi, ci, di;
    logic signed [IW-1:0] s0r, s0i, s2r, s2i, f1r, f1i, f3r, f3i;
    logic accept, hs;

    // Scaling: the unscaled result always fits OW; the /4 result fits DW+1
    // and is sign-extended. Rounding adds half an LSB before the shift.
    function automatic logic signed [OW-1:0] scl(input logic signed [IW-1:0] r,
                                                 input logic s);
        logic signed [IW-1:0] t;
`ifdef R4B_ROUND_EN
        t = r + IW'(2);
`else
        t = r;
`endif
        return s ? OW'(t >>> 2) : OW'(r);
    endfunction

    assign ar = {{3{xr0[DW-1]}}, xr0};
    assign br = {{3{xr1[DW-1]}}, xr1};
    assign cr = {{3{xr2[DW-1]}}, xr2};
    assign dr = {{3{xr3[DW-1]}}, xr3};
    assign ai = {{3{xi0[DW-1]}}, xi0};
    assign bi = {{3{xi1[DW-1]}}, xi1};
    assign ci = {{3{xi2[DW-1]}}, xi2};
    assign di = {{3{xi3[DW-1]}}, xi3};

    assign out_valid = (state_q == EMIT);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == 2'd3);
    assign Xro       = xro_q;
    assign Xio       = xio_q;
    assign in_ready  = rdy_en_q && ((state_q == IDLE) || ((idx_q == 2'd3) && out_ready));
    assign accept    = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign nidx      = idx_q + 2'd1;

    // Butterfly arithmetic on the live inputs; inverse swaps X1 and X3.
    always_comb begin
        s0r = ar + br + cr + dr;
        s0i = ai + bi + ci + di;
        s2r = ar - br + cr - dr;
        s2i = ai - bi + ci - di;
        f1r = ar + bi - cr - di;
        f1i = ai - br - ci + dr;
        f3r = ar - bi - cr + di;
        f3i = ai + br - ci - dr;
        new_r[0] = scl(s0r, scale);
        new_i[0] = scl(s0i, scale);
        new_r[2] = scl(s2r, scale);
        new_i[2] = scl(s2i, scale);
        new_r[1] = scl(inv ? f3r : f1r, scale);
        new_i[1] = scl(inv ? f3i : f1i, scale);
        new_r[3] = scl(inv ? f1r : f3r, scale);
        new_i[3] = scl(inv ? f1i : f3i, scale);
    end

    // Next-state: accept has priority so a block arriving on the last
    // handshake reloads the buffer without a bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        xro_d   = xro_q;
        xio_d   = xio_q;
        buf_r_d = buf_r_q;
        buf_i_d = buf_i_q;
        if (accept) begin
            buf_r_d = new_r;
            buf_i_d = new_i;
            xro_d   = new_r[0];
            xio_d   = new_i[0];
            idx_d   = 2'd0;
            state_d = EMIT;
        end else if (hs) begin
            if (idx_q == 2'd3) begin
                idx_d   = 2'd0;
                state_d = IDLE;
            end else begin
                idx_d = nidx;
                xro_d = buf_r_q[nidx];
                xio_d = buf_i_q[nidx];
            end
        end
    end

    // State and output registers; in_ready is held low for the reset cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
            idx_q    <= 2'd0;
            xro_q    <= '0;
            xio_q    <= '0;
            buf_r_q  <= '{default: '0};
            buf_i_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            idx_q    <= idx_d;
            xro_q    <= xro_d;
            xio_q    <= xio_d;
            buf_r_q  <= buf_r_d;
            buf_i_q  <= buf_i_d;
        end
    end

endmodule

// File: tb/tb_r4_butterfly_stream.sv
module tb_r4_butterfly_stream;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3;
    logic              inv, scale;
    logic              out_valid;
    logic              out_ready;
    logic signed [9:0] Xro, Xio;
    logic [1:0]        out_idx;
    logic              out_last;

    typedef struct {
        int re;
        int im;
        int idx;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int acc_idx;
    bit acc_valid;

    r4_butterfly_stream #(.DW(8)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
        .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
        .inv(inv), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .Xro(Xro), .Xio(Xio), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Monitor: pops and checks each output the sink actually takes.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output idx=%0d re=%0d im=%0d", out_idx, Xro, Xio);
            end else begin
                e = q.pop_front();
                if (int'(Xro) != e.re || int'(Xio) != e.im || int'(out_idx) != e.idx
                    || out_last != (e.idx == 3)) begin
                    bad++;
                    $display("FAIL out_x%0d got=(%0d,%0d) idx=%0d last=%0d want=(%0d,%0d) idx=%0d last=%0d",
                             e.idx, Xro, Xio, out_idx, out_last, e.re, e.im, e.idx, (e.idx == 3));
                end
            end
        end
    end

    // Present one block, push its expected outputs when accepted.
    task automatic send(input int d[8], input bit iv, input bit sc, input int e[8]);
        bit got = 0;
        exp_t x;
        xr0 = 8'(d[0]); xi0 = 8'(d[1]);
        xr1 = 8'(d[2]); xi1 = 8'(d[3]);
        xr2 = 8'(d[4]); xi2 = 8'(d[5]);
        xr3 = 8'(d[6]); xi3 = 8'(d[7]);
        inv = iv; scale = sc; in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (in_ready) begin
                for (int k = 0; k < 4; k++) begin
                    x.re = e[2*k]; x.im = e[2*k+1]; x.idx = k;
                    q.push_back(x);
                end
                acc_idx = int'(out_idx);
                acc_valid = out_valid;
                got = 1;
                break;
            end
        end
        if (!got) begin
            bad++; total++;
            $display("FAIL accept_timeout got=0 want=1");
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        inv = ~iv; scale = ~sc;
        xr0 = 8'sd99; xi0 = -8'sd77; xr1 = 8'sd5; xi1 = 8'sd1;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (!out_valid && q.size() == 0) begin
                done = 1;
                break;
            end
        end
        chk(nm, int'(done), 1);
    endtask

    int v1[8]  = '{10, 0, 20, 0, 30, 0, 40, 0};
    int e1f[8] = '{100, 0, -20, 20, -20, 0, -20, -20};
    int e1i[8] = '{100, 0, -20, -20, -20, 0, -20, 20};
    int v3[8]  = '{12, 0, 20, 0, 30, 0, 40, 0};
`ifdef R4B_ROUND_EN
    int e3[8]  = '{26, 0, -4, 5, -4, 0, -4, -5};
`else
    int e3[8]  = '{25, 0, -5, 5, -5, 0, -5, -5};
`endif
    int v4[8]  = '{-128, -128, -128, -128, -128, -128, -128, -128};
    int e4[8]  = '{-512, -512, 0, 0, 0, 0, 0, 0};
    int va[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int ea[8]  = '{16, 20, -8, 0, -4, -4, 0, -8};

    initial begin
        int sr, si;
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0; scale = 1'b0;
        xr0 = 0; xr1 = 0; xr2 = 0; xr3 = 0; xi0 = 0; xi1 = 0; xi2 = 0; xi3 = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_xro", int'(Xro), 0);
        chk("rst_xio", int'(Xio), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        send(v1, 1'b0, 1'b0, e1f);
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_idx", int'(out_idx), 0);
        wait_idle("drain_fwd");

        send(v1, 1'b1, 1'b0, e1i);
        wait_idle("drain_inv");

        send(v3, 1'b0, 1'b1, e3);
        wait_idle("drain_scale");

        send(v4, 1'b0, 1'b0, e4);
        wait_idle("drain_neg_full");

        // Backpressure on idx1, then back-to-back second block.
        send(va, 1'b0, 1'b0, ea);
        @(posedge CLK); #1;
        out_ready = 1'b0;
        sr = int'(Xro); si = int'(Xio);
        chk("bp_idx_start", int'(out_idx), 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk("bp_idx_hold", int'(out_idx), 1);
            chk("bp_xro_hold", int'(Xro), sr);
            chk("bp_xio_hold", int'(Xio), si);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid_hold", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(v1, 1'b0, 1'b0, e1f);
        chk("b2b_accept_idx", acc_idx, 3);
        chk("b2b_accept_valid", int'(acc_valid), 1);
        chk("b2b_no_gap_valid", int'(out_valid), 1);
        chk("b2b_no_gap_idx", int'(out_idx), 0);
        wait_idle("drain_b2b");

        // Reset while idx2 is on the output.
        send(v1, 1'b0, 1'b0, e1f);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("midrst_idx_before", int'(out_idx), 2);
        RST = 1'b1;
        @(posedge CLK); #1;
        q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_xro", int'(Xro), 0);
        chk("midrst_xio", int'(Xio), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_in_ready_after", int'(in_ready), 1);
        chk("midrst_no_partial", int'(out_valid), 0);
        @(posedge CLK); #1;
        chk("midrst_no_partial2", int'(out_valid), 0);

        send(v4, 1'b0, 1'b0, e4);
        wait_idle("drain_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
